vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Source end of the raster interface consumed by the paddle, ball and score blocks.
- Generates hcount/vcount and hsync/vsync for 640x480@60 Hz.
- Accepts the OR-combined 1-bit r/g/b from the game objects, blanks them outside the active area, and drives the VGA pins with all pin signals aligned.
- Sits at top level, between the pixel clock and the game-object modules.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  input  1  pixel clock, 25.175 MHz (50 MHz when CLK_DIV2_EN is defined)
rst  input  1  reset, asynchronous, active-high
hcount  output  10  current pixel column, 0..H_TOTAL-1
vcount  output  10  current line, 0..V_TOTAL-1
hsync  output  1  timing-domain hsync, active low, aligned with hcount/vcount
vsync  output  1  timing-domain vsync, active low, aligned; paddles update on its falling edge
video_on  output  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE
frame_start  output  1  one-clk pulse at start of each new frame
pix_en  output  1  pixel-advance strobe
r_in, g_in, b_in  input  1 each  pixel colour from game objects, combinational from hcount/vcount
vga_r, vga_g, vga_b  output  1 each  blanked, registered colour pins
vga_hs, vga_vs  output  1 each  sync pins, delayed to align with vga_r/g/b

Behaviour:
- H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525). Frame = 420000 pixel periods.
- All state advances only on clk rising edges where pix_en=1. When pix_en=0, every register holds.
- hcount increments each pixel. At H_TOTAL-1 it wraps to 0 and vcount increments. vcount wraps to 0 at V_TOTAL-1 when hcount is also H_TOTAL-1.
- Counters never exceed their totals. No other wrap path exists.
- hsync=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491). vsync covers whole lines.
- hsync, vsync and video_on are registered from the next-state counter values, so they are consistent with hcount/vcount in the same cycle (zero skew).
- frame_start = 1 for exactly one clk, in the cycle after the counters transition (H_TOTAL-1, V_TOTAL-1) -> (0,0). It is not asserted on reset release.
- Pixel pipeline, one pixel-period latency:
  - On each pix_en edge, vga_r <= r_in & video_on (same for g and b).
  - vga_hs <= hsync and vga_vs <= vsync, so pins stay mutually aligned.
- Reset values, applied asynchronously:
  - hcount=0, vcount=0, hsync=1, vsync=1, video_on=1, frame_start=0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1.
- Reset mid-frame: all outputs return to reset values immediately. After release, counting restarts at (0,0) with no partial sync pulse; any sync pulse in progress is terminated.
- r_in/g_in/b_in are ignored while video_on=0 and while rst=1.

Optional Feature:
- Macro: CLK_DIV2_EN.
- Defined: clk is 50 MHz. An internal toggle flop (reset 0, flips every clk) drives pix_en. The first counter advance occurs on the second clk edge after reset release. frame_start remains one clk wide and is asserted only in a pix_en=1 cycle.
- Not defined: pix_en is tied to 1 and clk is the pixel clock.

Test Plan:
- Reset: hold rst 5 clks, release -> hcount=0, vcount=0, hsync=1, vsync=1, vga_r=0, frame_start=0. First pix_en edge -> hcount=1.
- Line timing: run one line -> hsync low for exactly 96 pixels, first low at hcount=656, high again at 752. hcount wraps 799->0 and vcount 0->1 on the same edge.
- Frame timing: run 2 frames -> vsync low exactly 1600 pixels (vcount 490-491). frame_start pulses are 420000 pixels apart. vcount never reaches 525.
- Blanking: force r_in=g_in=b_in=1 for a full frame -> vga_r high only for pixels with hcount<640 and vcount<480, one pixel after the matching hcount. Total high count = 307200.
- Mid-frame reset: assert rst at (300,200) for 3 clks -> outputs at reset values during rst. After release, counting restarts at (0,0) and the next frame_start comes 420000 pixels later.
- CLK_DIV2_EN defined: counters advance every second clk. Frame = 840000 clks. frame_start width = 1 clk. Sync widths double in clk units.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source with blanked, pin-aligned colour/sync outputs.
// Define CLK_DIV2_EN to run from a 2x clock with an internal pixel-enable toggle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       pix_en,
  input  logic       r_in,
  input  logic       g_in,
  input  logic       b_in,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       vga_hs,
  output logic       vga_vs
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAct    = 10'(H_ACTIVE);
  localparam logic [9:0] VAct    = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef CLK_DIV2_EN
  logic pix_en_q, pix_en_d;

  assign pix_en_d = ~pix_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en_q <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;
`else
  assign pix_en = 1'b1;
`endif

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       vga_r_q, vga_r_d;
  logic       vga_g_q, vga_g_d;
  logic       vga_b_q, vga_b_d;
  logic       vga_hs_q, vga_hs_d;
  logic       vga_vs_q, vga_vs_d;
  logic       line_end, frame_end;

  // Next-state values assume an advance; the register enable makes them hold otherwise.
  always_comb begin
    line_end  = (hcount_q == HLast);
    frame_end = line_end && (vcount_q == VLast);

    hcount_d = line_end ? 10'd0 : hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (frame_end) begin
      vcount_d = 10'd0;
    end else if (line_end) begin
      vcount_d = vcount_q + 10'd1;
    end

    // Decoded from the next counters so the flags line up with hcount/vcount.
    hsync_d       = !((hcount_d >= HsStart) && (hcount_d < HsEnd));
    vsync_d       = !((vcount_d >= VsStart) && (vcount_d < VsEnd));
    video_on_d    = (hcount_d < HAct) && (vcount_d < VAct);
    frame_start_d = frame_end;

    vga_r_d  = r_in & video_on_q;
    vga_g_d  = g_in & video_on_q;
    vga_b_d  = b_in & video_on_q;
    vga_hs_d = hsync_q;
    vga_vs_d = vsync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
      vga_r_q       <= 1'b0;
      vga_g_q       <= 1'b0;
      vga_b_q       <= 1'b0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
    end else if (pix_en) begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
    end
  end

  assign hcount   = hcount_q;
  assign vcount   = vcount_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_on_q;
  // The flop spans a whole pixel period; gating keeps the pulse one clk wide.
  assign frame_start = frame_start_q & pix_en;
  assign vga_r    = vga_r_q;
  assign vga_g    = vga_g_q;
  assign vga_b    = vga_b_q;
  assign vga_hs   = vga_hs_q;
  assign vga_vs   = vga_vs_q;

endmodule
